// File: rtl/cpu_pkg.sv
// Shared CPU types: the fetch-to-decode payload, the fetch FSM states and the boot PC.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_payload_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        OUT
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_unit.sv
// Non-pipelined instruction fetch: owns the PC, issues one memory request at a time
// and hands {pc, inst, fault} to decode, with redirects overriding everything else.
module ifu_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter bit          ALIGN_TARGET = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           redirect_valid,
    input  logic [31:0]    redirect_target,
    output logic           imem_req_valid,
    input  logic           imem_req_ready,
    output logic [31:0]    imem_req_addr,
    input  logic           imem_resp_valid,
    output logic           imem_resp_ready,
    input  logic [31:0]    imem_resp_data,
    input  logic           imem_resp_err,
    output logic           out_valid,
    input  logic           out_ready,
    output fetch_payload_t out_payload
);

    ifu_state_e  state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic        fault_q;
    logic [31:0] target;
    logic        req_fire;
    logic        resp_fire;
    logic        out_fire;

    assign target = ALIGN_TARGET ? {redirect_target[31:2], 2'b00} : redirect_target;

    // Redirect gates both handshakes so a stale request or wrong-path handoff cannot fire.
    assign imem_req_valid  = (state == REQ) && !redirect_valid;
    assign imem_req_addr   = pc;
    assign imem_resp_ready = (state == WAIT) || (state == DROP);
    assign out_valid       = (state == OUT) && !redirect_valid;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_fire = imem_resp_valid && imem_resp_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        out_payload = '0;
        if (state == OUT) begin
            out_payload.pc    = pc;
            out_payload.inst  = inst_q;
            out_payload.fault = fault_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect_valid) pc <= target;
                end
                REQ: begin
                    if (redirect_valid) pc <= target;
                    else if (req_fire)  state <= WAIT;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= resp_fire ? REQ : DROP;
                    end else if (resp_fire) begin
                        inst_q  <= imem_resp_data;
                        fault_q <= imem_resp_err;
                        state   <= OUT;
                    end
                end
                DROP: begin
                    // The stale response still has to be drained even if another redirect lands with it.
                    if (redirect_valid) pc <= target;
                    if (resp_fire)      state <= REQ;
                end
                OUT: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (out_fire) begin
                        pc    <= pc + 32'd4;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    resp_only_when_expected: assert property (
        @(posedge clock) disable iff (reset)
        imem_resp_valid |-> ((state == WAIT) || (state == DROP))
    );

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Scoreboard bench for ifu_fetch_unit: a memory model plus an architectural PC model
// predict every delivered payload; directed scenarios cover reset, timing and redirects.
module tb_ifu_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] BOOT_PC = 32'h8000_0000;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           redirect_valid = 1'b0;
    logic [31:0]    redirect_target = '0;
    logic           imem_req_valid;
    logic           imem_req_ready = 1'b0;
    logic [31:0]    imem_req_addr;
    logic           imem_resp_valid = 1'b0;
    logic           imem_resp_ready;
    logic [31:0]    imem_resp_data = '0;
    logic           imem_resp_err = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    fetch_payload_t out_payload;

    int checks = 0;
    int passes = 0;

    // Memory model and architectural state shared between the monitor and the driver.
    bit             rand_mem = 1'b0;
    bit             force_dead = 1'b0;
    int             mem_lat = 1;
    bit             pending = 1'b0;
    int             age = 0;
    int             lat_cur = 1;
    int             pend_gen = 0;
    logic [31:0]    pend_addr = '0;
    int             gen = 0;
    logic [31:0]    model_pc = BOOT_PC;
    fetch_payload_t exp_q[$];
    bit             hold = 1'b0;
    fetch_payload_t held = '0;
    int             deliveries = 0;

    ifu_fetch_unit #(.RESET_PC(BOOT_PC), .ALIGN_TARGET(1'b1)) dut (
        .clock(clock),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_ready(imem_resp_ready),
        .imem_resp_data(imem_resp_data),
        .imem_resp_err(imem_resp_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_payload(out_payload)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        return h ^ 32'h0000_0013;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return a[5:2] == 4'h4;
    endfunction

    function automatic fetch_payload_t expect_at(input logic [31:0] a);
        fetch_payload_t p;
        p.pc    = a;
        p.inst  = inst_of(a);
        p.fault = err_of(a);
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] tgt, input logic ordy);
        @(posedge clock);
        #1;
        reset           = rst;
        redirect_valid  = rv;
        redirect_target = tgt;
        out_ready       = ordy;
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = imem_req_valid;
        end
        checkOutput({name, "_seen"}, 65'(seen), 65'd1);
        if (seen) checkOutput(name, 65'(imem_req_addr), 65'(exp_addr));
    endtask

    task automatic wait_out(input string name, input logic [31:0] exp_pc, output fetch_payload_t p);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid;
        end
        p = out_payload;
        checkOutput({name, "_seen"}, 65'(seen), 65'd1);
        if (seen) checkOutput(name, 65'(p.pc), 65'(exp_pc));
    endtask

    // Memory response driver: a response appears lat_cur cycles after the request is accepted.
    always @(posedge clock) begin
        #1;
        imem_req_ready = rand_mem ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (pending && (age + 1 >= lat_cur)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = force_dead ? 32'hDEAD_BEEF : inst_of(pend_addr);
            imem_resp_err   = err_of(pend_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            imem_resp_err   = 1'b0;
        end
    end

    // Monitor: everything sampled here is what the next rising edge will act on.
    always @(negedge clock) begin
        if (reset) begin
            model_pc = BOOT_PC;
            exp_q.delete();
            gen++;
            pending = 1'b0;
            hold    = 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                checkOutput("req_addr", 65'(imem_req_addr), 65'(model_pc));
                pending   = 1'b1;
                age       = 0;
                pend_gen  = gen;
                pend_addr = imem_req_addr;
                lat_cur   = rand_mem ? $urandom_range(1, 3) : mem_lat;
            end else if (pending) begin
                if (imem_resp_valid && imem_resp_ready) begin
                    pending = 1'b0;
                    if (!redirect_valid && pend_gen == gen) exp_q.push_back(expect_at(model_pc));
                end else begin
                    age++;
                end
            end

            if (out_valid && out_ready) begin
                fetch_payload_t e;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checkOutput("payload", 65'(out_payload), 65'(e));
                model_pc = model_pc + 32'd4;
                deliveries++;
            end

            if (hold && out_valid) checkOutput("payload_hold", 65'(out_payload), 65'(held));
            hold = out_valid && !out_ready;
            held = out_payload;

            if (redirect_valid) begin
                gen++;
                model_pc = redirect_target & ~32'd3;
                exp_q.delete();
            end
        end
    end

    initial begin
        fetch_payload_t p;
        fetch_payload_t first;
        int start_deliveries;

        repeat (2) @(negedge clock);
        checkOutput("rst_req_valid",  65'(imem_req_valid),  65'd0);
        checkOutput("rst_resp_ready", 65'(imem_resp_ready), 65'd0);
        checkOutput("rst_out_valid",  65'(out_valid),       65'd0);
        checkOutput("rst_req_addr",   65'(imem_req_addr),   65'(BOOT_PC));
        checkOutput("rst_payload",    65'(out_payload),     65'd0);

        // Zero-wait memory after release: request in cycle 1, deliveries every third cycle.
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checkOutput($sformatf("out_valid_c%0d", k), 65'(out_valid), 65'(k > 0 && k % 3 == 0));
            if (k == 1) checkOutput("first_req", 65'({imem_req_valid, imem_req_addr}), 65'({1'b1, BOOT_PC}));
            if (k > 0 && k % 3 == 0)
                checkOutput($sformatf("out_pc_c%0d", k), 65'(out_payload.pc), 65'(BOOT_PC + 32'(4 * (k / 3 - 1))));
        end

        // Decode stalls for five cycles.
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        wait_out("stall_pc", 32'h8000_000C, first);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("stall_valid", 65'(out_valid), 65'd1);
            checkOutput("stall_payload", 65'(out_payload), 65'(first));
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        wait_req("after_stall_addr", 32'h8000_0010);

        // Faulting fetch is delivered as an ordinary payload.
        wait_out("fault_pc", 32'h8000_0010, p);
        checkOutput("fault_bit", 65'(p.fault), 65'd1);
        mem_lat    = 3;
        force_dead = 1'b1;
        wait_req("after_fault_addr", 32'h8000_0014);

        // Redirect while waiting on a slow response; the late response must be dropped.
        applyStimulus(1'b0, 1'b1, 32'h8000_0100, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        mem_lat = 1;
        wait_req("wait_redirect_addr", 32'h8000_0100);
        force_dead = 1'b0;

        // Redirect in OUT with decode ready in the same cycle.
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        wait_out("pre_out_redirect_pc", 32'h8000_0100, p);
        applyStimulus(1'b0, 1'b1, 32'h8000_0200, 1'b1);
        @(negedge clock);
        checkOutput("out_gated_by_redirect", 65'(out_valid), 65'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        wait_req("out_redirect_addr", 32'h8000_0200);

        // Unaligned redirect target is forced to a word boundary.
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        wait_out("pre_align_pc", 32'h8000_0200, p);
        applyStimulus(1'b0, 1'b1, 32'h8000_0303, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        wait_req("aligned_addr", 32'h8000_0300);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        wait_out("aligned_pc", 32'h8000_0300, p);
        mem_lat = 3;
        wait_req("pre_reset_addr", 32'h8000_0304);

        // Reset while a request is outstanding.
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        #1;
        checkOutput("midrst_req_valid",  65'(imem_req_valid),  65'd0);
        checkOutput("midrst_resp_ready", 65'(imem_resp_ready), 65'd0);
        checkOutput("midrst_out_valid",  65'(out_valid),       65'd0);
        checkOutput("midrst_payload",    65'(out_payload),     65'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        mem_lat = 1;
        wait_req("post_reset_addr", BOOT_PC);

        // Randomised traffic against the scoreboard.
        rand_mem = 1'b1;
        start_deliveries = deliveries;
        repeat (400) begin
            logic rv;
            logic [31:0] tgt;
            rv  = ($urandom_range(0, 9) == 0);
            tgt = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            applyStimulus(1'b0, rv, tgt, ($urandom_range(0, 9) < 7));
        end
        repeat (20) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("random_progress", 65'(deliveries - start_deliveries >= 20), 65'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
